// File: rtl/koopa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// koopa_ctrl_pkg
// Shared definitions for the koopa enemy controller:
//   - shell FSM state encoding (WALK/SHELL/SLIDE/REVIVE)
//   - default sprite id constants
//   - event vector layout used by the toggle detectors
//   - object lookup (sprite id -> width/height) used by the renderer and
//     the collision engine
// -----------------------------------------------------------------------------
package koopa_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WALK   = 2'b00,
        ST_SHELL  = 2'b01,
        ST_SLIDE  = 2'b10,
        ST_REVIVE = 2'b11
    } koopa_state_e;

    localparam int unsigned DEF_ID_WALK0_BASE = 32;
    localparam int unsigned DEF_ID_WALK1_BASE = 34;
    localparam int unsigned DEF_ID_SHELL_BASE = 21;
    localparam int unsigned DEF_ID_NULL       = 63;

    // Bit positions in the event vector produced by the toggle detectors.
    localparam int N_EVT     = 3;
    localparam int EVT_ANIM  = 0;
    localparam int EVT_COL   = 1;
    localparam int EVT_PRESS = 2;

    typedef struct packed {
        logic [10:0] w;
        logic [10:0] h;
    } obj_size_t;

    // Object table: the null sprite has no extent, the walking sprites are
    // taller than one tile, everything else (shell frames) is a 16x16 tile.
    function automatic obj_size_t object_size(input logic [5:0] obj_id);
        obj_size_t sz;
        sz.w = 11'd16;
        sz.h = 11'd16;
        if (obj_id == 6'd63) begin
            sz.w = 11'd0;
            sz.h = 11'd0;
        end else if (obj_id >= 6'd32 && obj_id <= 6'd41) begin
            sz.h = 11'd24;
        end
        return sz;
    endfunction

endpackage

// File: rtl/koopa_ctrl_toggle_detect.sv
// -----------------------------------------------------------------------------
// koopa_ctrl_toggle_detect
// Armed level-change detector for toggle-style inputs. The first clock after
// reset only captures the input level (arming); afterwards every level change
// raises evt_o for the cycle in which the change is visible.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active high
//   sig_i  in  toggle input
//   evt_o  out one-cycle event, combinational from pre_q / armed_q and sig_i
// -----------------------------------------------------------------------------
module koopa_ctrl_toggle_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic evt_o
);

    logic pre_q;
    logic armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pre_q   <= sig_i;
            armed_q <= 1'b1;
        end
    end

    assign evt_o = armed_q & (pre_q ^ sig_i);

endmodule

// File: rtl/koopa_ctrl.sv
// -----------------------------------------------------------------------------
// koopa_ctrl
// Turtle/koopa enemy controller with a four-state shell FSM
// (WALK -> SHELL -> SLIDE / REVIVE -> WALK). Produces the sprite id and the
// sprite size for the renderer and the collision engine.
// Ports:
//   clk                 in   system clock
//   rstn                in   asynchronous reset, ACTIVE HIGH despite the name
//   clk_walk_anim       in   toggle; each level change is one anim tick
//   initial_show        in   1 = enemy visible and active
//   collapsion_impulse  in   toggle; change = wall/enemy collision
//   press_impulse       in   toggle; change = stomped by player
//   kick_dir            in   heading given to the shell on a kick
//   id                  out  sprite id (ID_NULL while hidden)
//   oriental            out  0 = right, 1 = left
//   w, h                out  sprite size from the object table
//   shell               out  1 when state != WALK
//   sliding             out  1 when state == SLIDE
//   state               out  raw FSM state encoding
// -----------------------------------------------------------------------------
module koopa_ctrl
    import koopa_ctrl_pkg::*;
#(
    parameter int unsigned N_WALK_FRAMES = 2,
    parameter int unsigned REVIVE_TICKS  = 8,
    parameter int unsigned WOBBLE_TICKS  = 4,
    parameter bit          SLIDE_EN      = 1'b1,
    parameter int unsigned ID_WALK0_BASE = DEF_ID_WALK0_BASE,
    parameter int unsigned ID_WALK1_BASE = DEF_ID_WALK1_BASE,
    parameter int unsigned ID_SHELL_BASE = DEF_ID_SHELL_BASE,
    parameter int unsigned ID_NULL       = DEF_ID_NULL
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clk_walk_anim,
    input  logic        initial_show,
    input  logic        collapsion_impulse,
    input  logic        press_impulse,
    input  logic        kick_dir,
    output logic [5:0]  id,
    output logic        oriental,
    output logic [10:0] w,
    output logic [10:0] h,
    output logic        shell,
    output logic        sliding,
    output logic [1:0]  state
);

    localparam logic [2:0] WALK_LAST   = 3'(N_WALK_FRAMES - 1);
    localparam logic [7:0] REVIVE_LAST = 8'(REVIVE_TICKS - 1);
    localparam logic [7:0] WOBBLE_LAST = 8'(WOBBLE_TICKS - 1);

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic [N_EVT-1:0] impulse_raw;
    logic [N_EVT-1:0] evt;

    assign impulse_raw[EVT_ANIM]  = clk_walk_anim;
    assign impulse_raw[EVT_COL]   = collapsion_impulse;
    assign impulse_raw[EVT_PRESS] = press_impulse;

    generate
        for (genvar gi = 0; gi < N_EVT; gi++) begin : g_det
            koopa_ctrl_toggle_detect u_det (
                .clk   (clk),
                .rst   (rstn),
                .sig_i (impulse_raw[gi]),
                .evt_o (evt[gi])
            );
        end
    endgenerate

    // The detectors keep tracking while hidden, so gating here discards any
    // toggle seen while hidden instead of replaying it on reappearance.
    logic ev_tick;
    logic ev_col;
    logic ev_press;

    assign ev_tick  = initial_show & evt[EVT_ANIM];
    assign ev_col   = initial_show & evt[EVT_COL];
    assign ev_press = initial_show & evt[EVT_PRESS];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    koopa_state_e state_q, state_d;
    logic         ori_q, ori_d;
    logic [2:0]   walk_frame_q, walk_frame_d;
    logic [1:0]   shell_frame_q, shell_frame_d;
    logic [7:0]   tick_cnt_q, tick_cnt_d;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q       <= ST_WALK;
            ori_q         <= 1'b1;
            walk_frame_q  <= 3'd0;
            shell_frame_q <= 2'd0;
            tick_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            ori_q         <= ori_d;
            walk_frame_q  <= walk_frame_d;
            shell_frame_q <= shell_frame_d;
            tick_cnt_q    <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A press always wins over a tick in the same cycle;
    // collisions are only honoured in WALK and SLIDE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ori_d         = ori_q;
        walk_frame_d  = walk_frame_q;
        shell_frame_d = shell_frame_q;
        tick_cnt_d    = tick_cnt_q;

        case (state_q)
            ST_WALK: begin
                if (ev_col) begin
                    ori_d = ~ori_q;
                end
                if (ev_press) begin
                    state_d    = ST_SHELL;
                    tick_cnt_d = 8'd0;
                end else if (ev_tick) begin
                    walk_frame_d = (walk_frame_q >= WALK_LAST) ? 3'd0 : walk_frame_q + 3'd1;
                end
            end

            ST_SHELL: begin
                // Kick heading replaces the orientation outright, so a
                // coincident collision has no effect here.
                if (ev_press && SLIDE_EN) begin
                    state_d       = ST_SLIDE;
                    ori_d         = kick_dir;
                    shell_frame_d = 2'd0;
                end else if (ev_tick) begin
                    if (tick_cnt_q >= REVIVE_LAST) begin
                        state_d    = ST_REVIVE;
                        tick_cnt_d = 8'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end

            ST_SLIDE: begin
                if (ev_col) begin
                    ori_d = ~ori_q;
                end
                if (ev_press) begin
                    state_d    = ST_SHELL;
                    tick_cnt_d = 8'd0;
                end else if (ev_tick) begin
                    shell_frame_d = shell_frame_q + 2'd1;
                end
            end

            ST_REVIVE: begin
                if (ev_press) begin
                    state_d    = ST_SHELL;
                    tick_cnt_d = 8'd0;
                end else if (ev_tick) begin
                    shell_frame_d[0] = ~shell_frame_q[0];
                    if (tick_cnt_q >= WOBBLE_LAST) begin
                        state_d      = ST_WALK;
                        walk_frame_d = 3'd0;
                        tick_cnt_d   = 8'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [5:0] id_vis;

    always_comb begin
        id_vis = 6'(ID_SHELL_BASE);
        case (state_q)
            ST_WALK:   id_vis = (ori_q ? 6'(ID_WALK1_BASE) : 6'(ID_WALK0_BASE))
                                + {3'b000, walk_frame_q};
            ST_SHELL:  id_vis = 6'(ID_SHELL_BASE);
            ST_SLIDE:  id_vis = 6'(ID_SHELL_BASE) + {4'b0000, shell_frame_q};
            ST_REVIVE: id_vis = 6'(ID_SHELL_BASE) + {5'b00000, shell_frame_q[0]};
            default: ;
        endcase
    end

    obj_size_t obj_sz;

    assign id       = initial_show ? id_vis : 6'(ID_NULL);
    assign obj_sz   = object_size(id);
    assign w        = obj_sz.w;
    assign h        = obj_sz.h;
    assign oriental = ori_q;
    assign shell    = (state_q != ST_WALK);
    assign sliding  = (state_q == ST_SLIDE);
    assign state    = state_q;

endmodule

// File: tb/tb_koopa_ctrl.sv
// -----------------------------------------------------------------------------
// tb_koopa_ctrl
// Directed, table-driven bench. Instance A uses the default parameters,
// instance B is built with N_WALK_FRAMES=3, REVIVE_TICKS=2, SLIDE_EN=0.
// -----------------------------------------------------------------------------
module tb_koopa_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        a_rst, a_anim, a_show, a_col, a_press, a_kick;
    logic [5:0]  a_id;
    logic        a_ori, a_shell, a_sliding;
    logic [10:0] a_w, a_h;
    logic [1:0]  a_state;

    // Instance B
    logic        b_rst, b_anim, b_show, b_col, b_press, b_kick;
    logic [5:0]  b_id;
    logic        b_ori, b_shell, b_sliding;
    logic [10:0] b_w, b_h;
    logic [1:0]  b_state;

    koopa_ctrl u_dut_a (
        .clk                (clk),
        .rstn               (a_rst),
        .clk_walk_anim      (a_anim),
        .initial_show       (a_show),
        .collapsion_impulse (a_col),
        .press_impulse      (a_press),
        .kick_dir           (a_kick),
        .id                 (a_id),
        .oriental           (a_ori),
        .w                  (a_w),
        .h                  (a_h),
        .shell              (a_shell),
        .sliding            (a_sliding),
        .state              (a_state)
    );

    koopa_ctrl #(
        .N_WALK_FRAMES (3),
        .REVIVE_TICKS  (2),
        .SLIDE_EN      (1'b0)
    ) u_dut_b (
        .clk                (clk),
        .rstn               (b_rst),
        .clk_walk_anim      (b_anim),
        .initial_show       (b_show),
        .collapsion_impulse (b_col),
        .press_impulse      (b_press),
        .kick_dir           (b_kick),
        .id                 (b_id),
        .oriental           (b_ori),
        .w                  (b_w),
        .h                  (b_h),
        .shell              (b_shell),
        .sliding            (b_sliding),
        .state              (b_state)
    );

    typedef struct {
        logic        show;
        logic        ta;     // toggle anim
        logic        tc;     // toggle collapsion
        logic        tp;     // toggle press
        logic        kick;
        logic [1:0]  st;
        logic [5:0]  id;
        logic        ori;
        logic [10:0] w;
        logic [10:0] h;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input int show, input int ta, input int tc, input int tp,
                                input int kick, input int st, input int id, input int ori,
                                input int w, input int h);
        vec_t v;
        v.show = show[0];
        v.ta   = ta[0];
        v.tc   = tc[0];
        v.tp   = tp[0];
        v.kick = kick[0];
        v.st   = 2'(st);
        v.id   = 6'(id);
        v.ori  = ori[0];
        v.w    = 11'(w);
        v.h    = 11'(h);
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic run_vec(input int sel, input int idx, input vec_t v);
        logic [1:0]  g_st;
        logic [5:0]  g_id;
        logic        g_ori, g_sh, g_sl, e_sh, e_sl;
        logic [10:0] g_w, g_h;
        string       tag;
        if (sel == 0) begin
            a_show = v.show;
            a_kick = v.kick;
            if (v.ta) a_anim  = ~a_anim;
            if (v.tc) a_col   = ~a_col;
            if (v.tp) a_press = ~a_press;
        end else begin
            b_show = v.show;
            b_kick = v.kick;
            if (v.ta) b_anim  = ~b_anim;
            if (v.tc) b_col   = ~b_col;
            if (v.tp) b_press = ~b_press;
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            tag = "tab_a";
            g_st = a_state; g_id = a_id; g_ori = a_ori; g_sh = a_shell; g_sl = a_sliding;
            g_w = a_w; g_h = a_h;
        end else begin
            tag = "tab_b";
            g_st = b_state; g_id = b_id; g_ori = b_ori; g_sh = b_shell; g_sl = b_sliding;
            g_w = b_w; g_h = b_h;
        end
        e_sh = (v.st != 2'd0);
        e_sl = (v.st == 2'd2);
        n_vec++;
        if ({g_st, g_id, g_ori, g_sh, g_sl, g_w, g_h} !== {v.st, v.id, v.ori, e_sh, e_sl, v.w, v.h}) begin
            n_miss++;
            $display("FAIL %s[%0d]: got st=%0d id=%0d ori=%0d shell=%0d sliding=%0d w=%0d h=%0d, expected st=%0d id=%0d ori=%0d shell=%0d sliding=%0d w=%0d h=%0d",
                     tag, idx, g_st, g_id, g_ori, g_sh, g_sl, g_w, g_h,
                     v.st, v.id, v.ori, e_sh, e_sl, v.w, v.h);
        end else begin
            $display("ok   %s[%0d]: st=%0d id=%0d ori=%0d w=%0d h=%0d", tag, idx, g_st, g_id, g_ori, g_w, g_h);
        end
    endtask

    initial begin
        vec_t tab_a[$];
        vec_t tab_b[$];

        // show, ta, tc, tp, kick, | st, id, ori, w, h
        // Walk animation and turn-around
        tab_a.push_back(mk(1,1,0,0,1, 0,35,1, 16,24));
        tab_a.push_back(mk(1,1,0,0,1, 0,34,1, 16,24));
        tab_a.push_back(mk(1,1,0,0,1, 0,35,1, 16,24));
        tab_a.push_back(mk(1,1,0,0,1, 0,34,1, 16,24));
        tab_a.push_back(mk(1,0,1,0,1, 0,32,0, 16,24));
        tab_a.push_back(mk(1,1,0,0,1, 0,33,0, 16,24));
        tab_a.push_back(mk(1,0,0,0,1, 0,33,0, 16,24));
        // Stomp into SHELL, collision ignored, 8 ticks to REVIVE
        tab_a.push_back(mk(1,0,0,1,1, 1,21,0, 16,16));
        tab_a.push_back(mk(1,0,1,0,1, 1,21,0, 16,16));
        for (int i = 0; i < 7; i++) tab_a.push_back(mk(1,1,0,0,1, 1,21,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 3,21,0, 16,16));
        // Wobble then back to WALK with frame 0
        tab_a.push_back(mk(1,1,0,0,1, 3,22,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 3,21,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 3,22,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 0,32,0, 16,24));
        // Kick with kick_dir=0 plus a coincident collision: kick heading wins
        tab_a.push_back(mk(1,0,0,1,1, 1,21,0, 16,16));
        tab_a.push_back(mk(1,0,1,1,0, 2,21,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 2,22,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 2,23,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 2,24,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 2,21,0, 16,16));
        tab_a.push_back(mk(1,0,1,0,1, 2,21,1, 16,16));
        // Press + collision in SLIDE: both applied
        tab_a.push_back(mk(1,0,1,1,1, 1,21,0, 16,16));
        // Press + tick in SHELL: kick, tick dropped (shell frame stays 0)
        tab_a.push_back(mk(1,1,0,0,1, 1,21,0, 16,16));
        tab_a.push_back(mk(1,1,0,1,1, 2,21,1, 16,16));
        tab_a.push_back(mk(1,0,0,1,1, 1,21,1, 16,16));
        tab_a.push_back(mk(1,0,0,1,0, 2,21,0, 16,16));
        tab_a.push_back(mk(1,1,0,0,1, 2,22,0, 16,16));
        // Hidden: everything frozen, toggles discarded
        tab_a.push_back(mk(0,0,0,0,1, 2,63,0, 0,0));
        tab_a.push_back(mk(0,0,0,1,1, 2,63,0, 0,0));
        tab_a.push_back(mk(0,0,0,1,1, 2,63,0, 0,0));
        tab_a.push_back(mk(0,1,1,0,1, 2,63,0, 0,0));
        tab_a.push_back(mk(1,0,0,0,1, 2,22,0, 16,16));
        tab_a.push_back(mk(1,0,0,0,1, 2,22,0, 16,16));

        // Instance B: 3 walk frames, 2 revive ticks, press in SHELL ignored
        tab_b.push_back(mk(1,1,0,0,1, 0,35,1, 16,24));
        tab_b.push_back(mk(1,1,0,0,1, 0,36,1, 16,24));
        tab_b.push_back(mk(1,1,0,0,1, 0,34,1, 16,24));
        tab_b.push_back(mk(1,0,0,1,1, 1,21,1, 16,16));
        tab_b.push_back(mk(1,0,0,1,0, 1,21,1, 16,16));
        tab_b.push_back(mk(1,1,0,0,1, 1,21,1, 16,16));
        tab_b.push_back(mk(1,1,0,1,0, 3,21,1, 16,16));
        tab_b.push_back(mk(1,1,0,0,1, 3,22,1, 16,16));
        tab_b.push_back(mk(1,0,1,1,1, 1,21,1, 16,16));

        // Reset with every input held high
        a_rst = 1'b1; a_show = 1'b1; a_anim = 1'b1; a_col = 1'b1; a_press = 1'b1; a_kick = 1'b1;
        b_rst = 1'b1; b_show = 1'b1; b_anim = 1'b0; b_col = 1'b0; b_press = 1'b0; b_kick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   int'(a_state),   0);
        check("rst_id",      int'(a_id),      34);
        check("rst_ori",     int'(a_ori),     1);
        check("rst_shell",   int'(a_shell),   0);
        check("rst_sliding", int'(a_sliding), 0);
        check("rst_h",       int'(a_h),       24);

        // Arming clk must not see the 0 -> 1 difference as events
        a_rst = 1'b0;
        @(posedge clk);
        #1;
        check("arm_state", int'(a_state), 0);
        check("arm_id",    int'(a_id),    34);
        @(posedge clk);
        #1;
        check("post_arm_id", int'(a_id), 34);

        for (int i = 0; i < tab_a.size(); i++) run_vec(0, i, tab_a[i]);

        // Asynchronous reset in the middle of SLIDE, checked before any edge
        #3;
        a_rst = 1'b1;
        #1;
        check("async_rst_state", int'(a_state), 0);
        check("async_rst_id",    int'(a_id),    34);
        check("async_rst_ori",   int'(a_ori),   1);

        // Re-arming after reset, with inputs high so stale pre_* would fire
        a_anim = 1'b1; a_col = 1'b1; a_press = 1'b1; a_show = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        @(posedge clk);
        #1;
        check("rearm_state", int'(a_state), 0);
        check("rearm_id",    int'(a_id),    34);
        a_press = 1'b0;
        @(posedge clk);
        #1;
        check("rearm_press_state", int'(a_state), 1);

        // Instance B
        b_rst = 1'b0;
        @(posedge clk);
        #1;
        check("b_arm_id", int'(b_id), 34);
        for (int i = 0; i < tab_b.size(); i++) run_vec(1, i, tab_b[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
